// File: rtl/alu_pkg.sv
// Shared ALU definitions: operand/op widths, ALUOp codes and the response-register state encoding.
package alu_pkg;

    localparam int DATA_W = 32;
    localparam int OP_W   = 3;

    localparam logic [OP_W-1:0] ALU_ADD = 3'b000;
    localparam logic [OP_W-1:0] ALU_SUB = 3'b001;
    localparam logic [OP_W-1:0] ALU_OR  = 3'b010;
    localparam logic [OP_W-1:0] ALU_LW  = 3'b011;
    localparam logic [OP_W-1:0] ALU_SW  = 3'b100;
    localparam logic [OP_W-1:0] ALU_LUI = 3'b101;

    localparam logic ST_EMPTY = 1'b0;
    localparam logic ST_FULL  = 1'b1;

endpackage

// File: rtl/alu.sv
// Purely combinational 32-bit ALU: add/sub/or/pass-B by ALUOp, plus an operand-equality Zero flag.
module alu
    import alu_pkg::*;
#(
    parameter int DATA_W = alu_pkg::DATA_W,
    parameter int OP_W   = alu_pkg::OP_W
) (
    input  logic [DATA_W-1:0] sa,
    input  logic [DATA_W-1:0] sb,
    input  logic [OP_W-1:0]   op,
    output logic [DATA_W-1:0] result,
    output logic              zero
);

    always_comb begin
        result = '0;
        case (op)
            ALU_ADD, ALU_LW, ALU_SW: result = sa + sb;
            ALU_SUB:                 result = sa - sb;
            ALU_OR:                  result = sa | sb;
            ALU_LUI:                 result = sb;
            default:                 result = '0;
        endcase
    end

    // Zero reflects operand equality regardless of the op being executed
    assign zero = (sa == sb);

endmodule

// File: rtl/alu_rr_pick.sv
// Two-way request picker: round-robin on ptr, or fixed port-0 priority when ALU_ARB_FIXED_PRIO_EN is defined.
module alu_rr_pick (
    output logic [1:0] grant,
    input  logic [1:0] valid
`ifndef ALU_ARB_FIXED_PRIO_EN
    ,
    input  logic       ptr
`endif
);

    always_comb begin
        grant = 2'b00;
        if (valid == 2'b11) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            grant = 2'b01;
`else
            grant = ptr ? 2'b10 : 2'b01;
`endif
        end else begin
            grant = valid;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one shared ALU with a one-deep response register.
// Define ALU_ARB_FIXED_PRIO_EN for a fixed port-0-priority debug build (no round-robin pointer).
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_W = alu_pkg::DATA_W,
    parameter int OP_W   = alu_pkg::OP_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [2*DATA_W-1:0]   req_sa,
    input  logic [2*DATA_W-1:0]   req_sb,
    input  logic [2*OP_W-1:0]     req_op,
    output logic [1:0]            rsp_valid,
    input  logic [1:0]            rsp_ready,
    output logic [DATA_W-1:0]     rsp_result,
    output logic                  rsp_zero,
    output logic                  rsp_owner
);

    logic              state_q, state_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              zero_q, zero_d;
    logic              owner_q, owner_d;
    logic [1:0]        grant;
    logic              can_accept;
    logic              accept;
    logic              win;
    logic [DATA_W-1:0] alu_sa, alu_sb, alu_result;
    logic [OP_W-1:0]   alu_op;
    logic              alu_zero;

`ifdef ALU_ARB_FIXED_PRIO_EN
    alu_rr_pick u_pick (
        .grant (grant),
        .valid (req_valid)
    );
`else
    logic rr_ptr_q, rr_ptr_d;

    alu_rr_pick u_pick (
        .grant (grant),
        .valid (req_valid),
        .ptr   (rr_ptr_q)
    );
`endif

    // Port 0 drives the ALU whenever port 1 is not the picked requester
    assign alu_sa = grant[1] ? req_sa[DATA_W +: DATA_W] : req_sa[0 +: DATA_W];
    assign alu_sb = grant[1] ? req_sb[DATA_W +: DATA_W] : req_sb[0 +: DATA_W];
    assign alu_op = grant[1] ? req_op[OP_W +: OP_W]     : req_op[0 +: OP_W];

    alu #(
        .DATA_W (DATA_W),
        .OP_W   (OP_W)
    ) u_alu (
        .sa     (alu_sa),
        .sb     (alu_sb),
        .op     (alu_op),
        .result (alu_result),
        .zero   (alu_zero)
    );

    // A draining response frees the register in the same cycle, allowing back-to-back issue
    assign can_accept = (state_q == ST_EMPTY) || rsp_ready[owner_q];
    assign req_ready  = (can_accept && !reset) ? grant : 2'b00;
    assign accept     = |req_ready;
    assign win        = req_ready[1];

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        zero_d   = zero_q;
        owner_d  = owner_q;
`ifndef ALU_ARB_FIXED_PRIO_EN
        rr_ptr_d = rr_ptr_q;
        if (accept && req_valid == 2'b11)
            rr_ptr_d = ~win;
`endif
        if (accept) begin
            state_d  = ST_FULL;
            result_d = alu_result;
            zero_d   = alu_zero;
            owner_d  = win;
        end else if (state_q == ST_FULL && rsp_ready[owner_q]) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_EMPTY;
            result_q <= '0;
            zero_q   <= 1'b0;
            owner_q  <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            rr_ptr_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            owner_q  <= owner_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
            rr_ptr_q <= rr_ptr_d;
`endif
        end
    end

    assign rsp_valid  = (state_q == ST_FULL) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_result = result_q;
    assign rsp_zero   = zero_q;
    assign rsp_owner  = owner_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed, table-driven bench for alu_arbiter: per-cycle vectors with hand-computed grants and responses.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_sa;
    logic [63:0] req_sb;
    logic [5:0]  req_op;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_zero;
    logic        rsp_owner;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_sa     (req_sa),
        .req_sb     (req_sb),
        .req_op     (req_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .rsp_owner  (rsp_owner)
    );

    typedef struct {
        string       name;
        logic        rst;
        logic [1:0]  vld;
        logic [1:0]  rdy;
        logic [2:0]  op0;
        logic [31:0] sa0;
        logic [31:0] sb0;
        logic [2:0]  op1;
        logic [31:0] sa1;
        logic [31:0] sb1;
        logic [1:0]  e_rr;
        logic [1:0]  e_rv;
        logic [31:0] e_res;
        logic        e_z;
        logic        e_own;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string name, logic rst, logic [1:0] vld, logic [1:0] rdy,
                                logic [2:0] op0, logic [31:0] sa0, logic [31:0] sb0,
                                logic [2:0] op1, logic [31:0] sa1, logic [31:0] sb1,
                                logic [1:0] e_rr, logic [1:0] e_rv, logic [31:0] e_res,
                                logic e_z, logic e_own);
        vec_t v;
        v.name = name; v.rst = rst; v.vld = vld; v.rdy = rdy;
        v.op0 = op0; v.sa0 = sa0; v.sb0 = sb0;
        v.op1 = op1; v.sa1 = sa1; v.sb1 = sb1;
        v.e_rr = e_rr; v.e_rv = e_rv; v.e_res = e_res; v.e_z = e_z; v.e_own = e_own;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(logic rst, logic [1:0] vld, logic [1:0] rdy,
                         logic [2:0] op0, logic [31:0] sa0, logic [31:0] sb0,
                         logic [2:0] op1, logic [31:0] sa1, logic [31:0] sb1);
        reset     = rst;
        req_valid = vld;
        rsp_ready = rdy;
        req_op    = {op1, op0};
        req_sa    = {sa1, sa0};
        req_sb    = {sb1, sb0};
    endtask

    localparam bit FIXED =
`ifdef ALU_ARB_FIXED_PRIO_EN
        1'b1;
`else
        1'b0;
`endif

    initial begin
        drive(1'b1, 2'b00, 2'b00, 3'd0, 32'd0, 32'd0, 3'd0, 32'd0, 32'd0);

        // 1. reset then idle
        vecs.push_back(mk("reset", 1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk("idle", 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0));
        // 2. single port subtraction
        vecs.push_back(mk("p0_sub", 0, 2'b01, 2'b00, 3'b001, 5, 7, 0, 0, 0,
                          2'b01, 2'b01, 32'hFFFFFFFE, 0, 0));
        vecs.push_back(mk("p0_drain", 0, 2'b00, 2'b01, 0, 0, 0, 0, 0, 0,
                          2'b00, 2'b00, 32'hFFFFFFFE, 0, 0));
        // 3. tie and rotation
        vecs.push_back(mk("tie_a", 0, 2'b11, 2'b11, 3'b000, 3, 4, 3'b010, 32'hF0, 32'h0F,
                          2'b01, 2'b01, 7, 0, 0));
        if (FIXED) begin
            vecs.push_back(mk("tie_b", 0, 2'b11, 2'b11, 3'b000, 3, 4, 3'b010, 32'hF0, 32'h0F,
                              2'b01, 2'b01, 7, 0, 0));
        end else begin
            vecs.push_back(mk("tie_b", 0, 2'b11, 2'b11, 3'b000, 3, 4, 3'b010, 32'hF0, 32'h0F,
                              2'b10, 2'b10, 32'hFF, 0, 1));
        end
        vecs.push_back(mk("tie_c", 0, 2'b11, 2'b11, 3'b000, 3, 4, 3'b010, 32'hF0, 32'h0F,
                          2'b01, 2'b01, 7, 0, 0));
        vecs.push_back(mk("tie_drain", 0, 2'b00, 2'b11, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 7, 0, 0));
        // 4. backpressure on port 1; non-owner rsp_ready must be ignored
        vecs.push_back(mk("p1_lui", 0, 2'b10, 2'b00, 0, 0, 0, 3'b101, 0, 32'h1234,
                          2'b10, 2'b10, 32'h1234, 0, 1));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk("bp_hold", 0, 2'b01, 2'b01, 3'b000, 1, 2, 0, 0, 0,
                              2'b00, 2'b10, 32'h1234, 0, 1));
        vecs.push_back(mk("bp_release", 0, 2'b01, 2'b10, 3'b000, 1, 2, 0, 0, 0,
                          2'b01, 2'b01, 3, 0, 0));
        // 5. edge ops, issued back-to-back against a draining owner
        vecs.push_back(mk("add_wrap", 0, 2'b01, 2'b01, 3'b000, 32'hFFFFFFFF, 1, 0, 0, 0,
                          2'b01, 2'b01, 0, 0, 0));
        vecs.push_back(mk("op111_eq", 0, 2'b01, 2'b01, 3'b111, 9, 9, 0, 0, 0,
                          2'b01, 2'b01, 0, 1, 0));
        vecs.push_back(mk("op_lw", 0, 2'b01, 2'b01, 3'b011, 10, 20, 0, 0, 0,
                          2'b01, 2'b01, 30, 0, 0));
        vecs.push_back(mk("op_sw_eq", 0, 2'b01, 2'b01, 3'b100, 5, 5, 0, 0, 0,
                          2'b01, 2'b01, 10, 1, 0));
        vecs.push_back(mk("op110", 0, 2'b01, 2'b01, 3'b110, 1, 2, 0, 0, 0,
                          2'b01, 2'b01, 0, 0, 0));
        vecs.push_back(mk("sub_eq", 0, 2'b01, 2'b01, 3'b001, 3, 3, 0, 0, 0,
                          2'b01, 2'b01, 0, 1, 0));
        // 6. reset mid-response with owner=1, then a tie must go to port 0
        vecs.push_back(mk("p1_full", 0, 2'b10, 2'b01, 0, 0, 0, 3'b000, 2, 2,
                          2'b10, 2'b10, 4, 1, 1));
        vecs.push_back(mk("mid_reset", 1, 2'b11, 2'b00, 3'b000, 3, 4, 3'b010, 32'hF0, 32'h0F,
                          2'b00, 2'b00, 0, 0, 0));
        vecs.push_back(mk("post_reset_tie", 0, 2'b11, 2'b00, 3'b000, 3, 4, 3'b010, 32'hF0, 32'h0F,
                          2'b01, 2'b01, 7, 0, 0));
        vecs.push_back(mk("final_drain", 0, 2'b00, 2'b01, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 7, 0, 0));

        @(posedge clk);
        #1;
        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].vld, vecs[i].rdy, vecs[i].op0, vecs[i].sa0, vecs[i].sb0,
                  vecs[i].op1, vecs[i].sa1, vecs[i].sb1);
            #2;
            chk({vecs[i].name, ".req_ready"}, 32'(req_ready), 32'(vecs[i].e_rr));
            @(posedge clk);
            #1;
            chk({vecs[i].name, ".rsp_valid"}, 32'(rsp_valid), 32'(vecs[i].e_rv));
            chk({vecs[i].name, ".rsp_result"}, rsp_result, vecs[i].e_res);
            chk({vecs[i].name, ".rsp_zero"}, 32'(rsp_zero), 32'(vecs[i].e_z));
            chk({vecs[i].name, ".rsp_owner"}, 32'(rsp_owner), 32'(vecs[i].e_own));
        end

        // Continuous contention: count port-1 grants over four accepted cycles
        begin
            int g1;
            int g0;
            g1 = 0;
            g0 = 0;
            drive(1'b0, 2'b11, 2'b11, 3'b000, 3, 4, 3'b010, 32'hF0, 32'h0F);
            for (int c = 0; c < 4; c++) begin
                #2;
                if (req_ready[1]) g1++;
                if (req_ready[0]) g0++;
                @(posedge clk);
                #1;
            end
            chk("contend.p0_grants", 32'(g0), FIXED ? 32'd4 : 32'd2);
            chk("contend.p1_grants", 32'(g1), FIXED ? 32'd0 : 32'd2);
        end

        // Bounded wait: a stalled owner blocks all grants until it drains
        begin
            int waited;
            waited = 0;
            drive(1'b0, 2'b00, 2'b11, 0, 0, 0, 0, 0, 0);
            @(posedge clk);
            #1;
            drive(1'b0, 2'b10, 2'b00, 0, 0, 0, 3'b010, 32'h5, 32'hA);
            #2;
            chk("stall.first_grant", 32'(req_ready), 32'h2);
            @(posedge clk);
            #1;
            drive(1'b0, 2'b01, 2'b00, 3'b001, 32'h10, 32'h1, 0, 0, 0);
            for (int c = 0; c < 3; c++) begin
                #2;
                if (req_ready == 2'b00) waited++;
                @(posedge clk);
                #1;
            end
            chk("stall.blocked_cycles", 32'(waited), 32'd3);
            chk("stall.held_result", rsp_result, 32'hF);
            rsp_ready = 2'b10;
            #2;
            chk("stall.release_grant", 32'(req_ready), 32'h1);
            @(posedge clk);
            #1;
            chk("stall.new_result", rsp_result, 32'hF);
            chk("stall.new_owner", 32'(rsp_owner), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
